seg7_scan_311: RTL and testbench

//  - Downstream display stage for the 4-bit up/down counter: samples count (0..15) and direction.
//  - Splits the value into tens/units, then time-multiplexes two common-anode seven-segment digits.
//  - Decimal point on the units digit shows direction.
//  - Sits between the counter output and board display pins; single clock domain.

---
 rtl/seg7_pkg_311.sv | 20 ++
 rtl/bcd2seg_311.sv | 17 +
 rtl/seg7_scan_311.sv | 102 ++++++++++
 tb/tb_seg7_scan_311.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg_311.sv
// rtl/seg7_pkg_311.sv - shared constants and types for the two-digit seven-segment scanner
// Segment order is {g,f,e,d,c,b,a}; PAT is active-high, pins are active-low.
package seg7_pkg_311;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;
    localparam logic [1:0] AN_OFF    = 2'b11;

    localparam logic [6:0] PAT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/bcd2seg_311.sv
// rtl/bcd2seg_311.sv - decimal digit to active-low seven-segment pattern
// Non-decimal codes 10..15 produce a dark digit rather than a garbage glyph.
module bcd2seg_311
    import seg7_pkg_311::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        if (digit_i <= 4'd9) begin
            seg_n_o = ~PAT[digit_i];
        end
    end

endmodule

// File: rtl/seg7_scan_311.sv
// rtl/seg7_scan_311.sv - samples a 0..15 count and multiplexes it onto two common-anode digits
// Decimal point on the units digit lights while the counter counts up.
module seg7_scan_311
    import seg7_pkg_311::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk_311,
    input  logic       reset_311,
    input  logic [3:0] count_in_311,
    input  logic       ud_in_311,
    input  logic       hold_311,
    output logic [6:0] seg_311,
    output logic [1:0] an_311,
    output logic       dp_311
);

    localparam int                 DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [3:0]       val_q, val_d;
    logic             ud_q, ud_d;
    logic [DIV_W-1:0] div_q, div_d;
    slot_e            sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             tens;
    logic [3:0]       units;
    logic [3:0]       digit;
    logic [6:0]       dec_seg;

    // The counter changes on negedge, so its value is stable by the posedge we sample on.
    always_comb begin
        val_d = val_q;
        ud_d  = ud_q;
        if (!hold_311) begin
            val_d = count_in_311;
            ud_d  = ud_in_311;
        end
    end

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    always_comb begin
        sel_d = sel_q;
        if (tick) begin
            sel_d = (sel_q == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
        end
    end

    assign tens  = (val_q >= 4'd10);
    assign units = tens ? (val_q - 4'd10) : val_q;
    assign digit = (sel_q == SLOT_TENS) ? {3'b000, tens} : units;

    bcd2seg_311 u_dec (
        .digit_i (digit),
        .seg_n_o (dec_seg)
    );

    always_comb begin
        an_d  = AN_UNITS;
        seg_d = dec_seg;
        dp_d  = ~ud_q;
        if (sel_q == SLOT_TENS) begin
            an_d = AN_TENS;
            dp_d = 1'b1;
            if (BLANK_LZ && !tens) begin
                seg_d = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk_311) begin
        if (reset_311) begin
            val_q <= '0;
            ud_q  <= 1'b0;
            div_q <= '0;
            sel_q <= SLOT_UNITS;
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
            dp_q  <= 1'b1;
        end else begin
            val_q <= val_d;
            ud_q  <= ud_d;
            div_q <= div_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg_311 = seg_q;
    assign an_311  = an_q;
    assign dp_311  = dp_q;

endmodule

// File: tb/tb_seg7_scan_311.sv
// tb/tb_seg7_scan_311.sv - self-checking bench for seg7_scan_311
// Reference model tracks slot number and displayed value arithmetically.
module tb_seg7_scan_311;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count;
    logic       ud;
    logic       hold;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;

    always #5 clk = ~clk;

    seg7_scan_311 #(.REFRESH_DIV(R), .BLANK_LZ(1'b1)) dut (
        .clk_311      (clk),
        .reset_311    (reset),
        .count_in_311 (count),
        .ud_in_311    (ud),
        .hold_311     (hold),
        .seg_311      (seg),
        .an_311       (an),
        .dp_311       (dp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs after the k-th post-reset edge come from slot (k-1)/R
    logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         k = 0;
    int         mval = 0;
    logic       mud = 1'b0;
    bit         started = 1'b0;
    bit         done = 1'b0;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_dp;

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            e_seg = 7'h7F; e_an = 2'b11; e_dp = 1'b1;
            k = 0; mval = 0; mud = 1'b0;
        end else begin
            if (((k / R) % 2) == 0) begin
                e_an  = 2'b10;
                e_seg = ~pat_tab[mval % 10];
                e_dp  = ~mud;
            end else begin
                e_an  = 2'b01;
                e_seg = (mval < 10) ? 7'h7F : ~pat_tab[mval / 10];
                e_dp  = 1'b1;
            end
            k++;
            if (!hold) begin
                mval = int'(count);
                mud  = ud;
            end
        end
    end

    always @(negedge clk) begin
        if (started && !done) begin
            check("model_seg", {1'b0, seg}, {1'b0, e_seg});
            check("model_an", {6'b0, an}, {6'b0, e_an});
            check("model_dp", {7'b0, dp}, {7'b0, e_dp});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_an(input logic [1:0] want);
        bit found = 1'b0;
        for (int i = 0; i < 3 * R + 2; i++) begin
            @(negedge clk);
            if (an === want) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("slot_timeout", {6'b0, an}, {6'b0, want});
    endtask

    int len;

    initial begin
        reset = 1'b1; count = 4'd9; ud = 1'b0; hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_seg", {1'b0, seg}, 8'h7F);
            check("rst_an", {6'b0, an}, 8'h03);
            check("rst_dp", {7'b0, dp}, 8'h01);
        end

        reset = 1'b0; count = 4'd7; ud = 1'b1;
        @(negedge clk);
        check("first_an_units", {6'b0, an}, 8'h02);
        wait_an(2'b10);
        check("u7_seg", {1'b0, seg}, 8'h78);
        check("u7_dp", {7'b0, dp}, 8'h00);
        wait_an(2'b01);
        check("t0_seg", {1'b0, seg}, 8'h7F);
        check("t0_dp", {7'b0, dp}, 8'h01);
        len = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an !== 2'b01) break;
            len++;
        end
        check("slot_len", 8'(len), 8'(R));

        count = 4'd13;
        cycles(3);
        wait_an(2'b10);
        check("u3_seg", {1'b0, seg}, 8'h30);
        wait_an(2'b01);
        check("t1_seg", {1'b0, seg}, 8'h79);

        count = 4'd5;
        cycles(3);
        hold = 1'b1;
        for (int v = 6; v <= 9; v++) begin
            count = 4'(v);
            cycles(1);
        end
        wait_an(2'b10);
        check("hold_seg", {1'b0, seg}, 8'h12);
        hold = 1'b0;
        cycles(2);
        wait_an(2'b10);
        check("rel_seg", {1'b0, seg}, 8'h10);

        count = 4'd15;
        cycles(3);
        count = 4'd0;
        cycles(3);
        wait_an(2'b10);
        check("wrap_u_seg", {1'b0, seg}, 8'h40);
        wait_an(2'b01);
        check("wrap_t_seg", {1'b0, seg}, 8'h7F);

        ud = 1'b0;
        cycles(3);
        for (int i = 0; i < 2 * R; i++) begin
            @(negedge clk);
            check("down_dp", {7'b0, dp}, 8'h01);
        end

        count = 4'd10;
        cycles(3);
        wait_an(2'b01);
        cycles(1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_seg", {1'b0, seg}, 8'h7F);
        check("mid_rst_an", {6'b0, an}, 8'h03);
        reset = 1'b0;
        @(negedge clk);
        check("restart_an", {6'b0, an}, 8'h02);
        wait_an(2'b10);
        cycles(1);
        check("u10_seg", {1'b0, seg}, 8'h40);
        cycles(2 * R);

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
